// File: rtl/led_code_sequencer.sv
// Shares one LED between several requesters by playing per-requester blink codes
// (k pulses then a pause), granted round-robin with one code completing before the next.
module led_code_sequencer #(
  parameter int N_REQ     = 4,
  parameter int CODE_W    = 4,
  parameter int PULSE_CYC = 2_000_000,
  parameter int GAP_CYC   = 2_000_000,
  parameter int PAUSE_CYC = 8_000_000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*CODE_W-1:0]   code,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      done,
  output logic                      LED
);

  localparam int MAX_AB  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_AB > PAUSE_CYC) ? MAX_AB : PAUSE_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] PAUSE_LD = TMR_W'(PAUSE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, ON, OFF, PAUSE} state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CODE_W-1:0]   left_q, left_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N_REQ-1:0]    grant_q, grant_d;

  logic [CODE_W-1:0]   code_f [N_REQ];
  logic [N_REQ-1:0]    elig;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
    assign code_f[gi] = code[gi*CODE_W +: CODE_W];
    assign elig[gi]   = req[gi] && (code_f[gi] != '0);
  end

  // Scan downward so the last hit is the nearest eligible requester at or after rr_q.
  always_comb begin
    logic [IDX_W:0] slot;
    pick_found = 1'b0;
    pick_idx   = '0;
    slot       = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      slot = {1'b0, rr_q} + (IDX_W + 1)'(j);
      if (slot >= N_WIDE) begin
        slot = slot - N_WIDE;
      end
      if (elig[slot[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = slot[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      left_q  <= '0;
      cur_q   <= '0;
      rr_q    <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      grant_q <= grant_d;
    end
  end

  // Timer holds cycles remaining minus one; a phase ends on the cycle it reads zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    left_d  = left_q;
    cur_d   = cur_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = ON;
          timer_d = PULSE_LD;
          left_d  = code_f[pick_idx];
          cur_d   = pick_idx;
        end
      end
      ON: begin
        if (timer_q == '0) begin
          if (left_q > CODE_W'(1)) begin
            state_d = OFF;
            timer_d = GAP_LD;
            left_d  = left_q - CODE_W'(1);
          end else begin
            state_d = PAUSE;
            timer_d = PAUSE_LD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      OFF: begin
        if (timer_q == '0) begin
          state_d = ON;
          timer_d = PULSE_LD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      PAUSE: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          rr_d    = (cur_q == LAST_IDX) ? '0 : cur_q + IDX_W'(1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so pins never glitch.
  always_comb begin
    led_d   = (state_d == ON);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == PAUSE) && (state_d == IDLE);
    grant_d = '0;
    if (busy_d) begin
      grant_d[cur_d] = 1'b1;
    end
  end

  assign LED   = led_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_led_code_sequencer.sv
// Bench for led_code_sequencer: a queue-based reference model expands each granted code
// into its expected per-cycle LED/busy/done/grant waveform; directed and random scenarios.
module tb_led_code_sequencer;

  localparam int N_REQ     = 4;
  localparam int CODE_W    = 4;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 3;
  localparam int PAUSE_CYC = 5;
  localparam int W         = N_REQ + 3;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*CODE_W-1:0] code = '0;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic                    done;
  logic                    LED;

  int errors = 0;
  int checks = 0;

  // Expected output words {LED, busy, done, grant}, one per upcoming cycle.
  logic [W-1:0] exp_q[$];
  int           rr_m = 0;

  led_code_sequencer #(
    .N_REQ(N_REQ), .CODE_W(CODE_W),
    .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .PAUSE_CYC(PAUSE_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .code(code),
    .grant(grant), .busy(busy), .done(done), .LED(LED)
  );

  always #5 CLK = ~CLK;

  function automatic int oh2idx(input logic [N_REQ-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N_REQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic model_arbitrate();
    logic found;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      int idx;
      int k;
      logic [N_REQ-1:0] g;
      idx = (rr_m + j) % N_REQ;
      k = int'(code[idx*CODE_W +: CODE_W]);
      if (!found && req[idx] && k != 0) begin
        found = 1'b1;
        g = '0;
        g[idx] = 1'b1;
        for (int p = 1; p <= k; p++) begin
          repeat (PULSE_CYC) exp_q.push_back({1'b1, 1'b1, 1'b0, g});
          if (p < k) repeat (GAP_CYC) exp_q.push_back({1'b0, 1'b1, 1'b0, g});
        end
        repeat (PAUSE_CYC) exp_q.push_back({1'b0, 1'b1, 1'b0, g});
        exp_q.push_back({1'b0, 1'b0, 1'b1, {N_REQ{1'b0}}});
        rr_m = (idx + 1) % N_REQ;
      end
    end
  endtask

  // Advance one clock; returns what the DUT shows and what the model expects.
  task automatic tick(output logic [W-1:0] obs, output logic [W-1:0] exp_v);
    logic [W-1:0] e;
    e = '0;
    if (RST) begin
      exp_q.delete();
      rr_m = 0;
    end else begin
      if (exp_q.size() == 0) model_arbitrate();
      if (exp_q.size() != 0) e = exp_q.pop_front();
    end
    @(posedge CLK);
    #1;
    obs   = {LED, busy, done, grant};
    exp_v = e;
    if (obs[N_REQ]) $display("t=%0t done pulse observed", $time);
  endtask

  task automatic do_reset();
    logic [W-1:0] o, e;
    RST = 1'b1;
    req = '0;
    tick(o, e);
    tick(o, e);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] o, e;
    RST  = 1'b1;
    req  = 4'hF;
    code = 16'h5555;
    for (int c = 0; c < 2; c++) begin
      tick(o, e);
      checks++;
      if (o !== '0 || e !== '0) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", o, {W{1'b0}});
      end
    end
    RST = 1'b0;
    req = '0;
    tick(o, e);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", o, {W{1'b0}});
    end
    $display("test_reset complete");
  endtask

  task automatic test_single_code();
    logic [W-1:0] o, e;
    int done_t;
    logic exp_led;
    do_reset();
    req    = 4'b0001;
    code   = 16'h0003;
    done_t = -1;
    for (int t = 1; t <= 24; t++) begin
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single_model t=%0d: got %b expected %b", t, o, e);
      end
      exp_led = (t >= 1 && t <= 4) || (t >= 8 && t <= 11) || (t >= 15 && t <= 18);
      checks++;
      if (o[W-1] !== exp_led) begin
        errors++;
        $display("FAIL single_led t=%0d: got %b expected %b", t, o[W-1], exp_led);
      end
      if (o[N_REQ] === 1'b1 && done_t < 0) done_t = t;
    end
    req = '0;
    checks++;
    if (done_t !== 24) begin
      errors++;
      $display("FAIL single_done_time: got %0d expected 24", done_t);
    end
    $display("test_single_code: code 3 from requester 0 finished at t=%0d", done_t);
  endtask

  task automatic test_round_robin();
    logic [W-1:0] o, e;
    int order[$];
    int lens[$];
    int run;
    logic [N_REQ-1:0] prev;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req  = 4'hF;
    code = 16'h1111;
    prev = '0;
    run  = 0;
    for (int t = 1; t <= 50; t++) begin
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rr_model t=%0d: got %b expected %b", t, o, e);
      end
      if (o[N_REQ-1:0] != '0 && prev == '0) order.push_back(oh2idx(o[N_REQ-1:0]));
      if (o[N_REQ-1:0] != '0) run++;
      else if (prev != '0) begin
        lens.push_back(run);
        run = 0;
      end
      prev = o[N_REQ-1:0];
    end
    req = '0;
    checks++;
    if (order.size() < 5 || lens.size() < 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants expected 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] !== exp_order[i] || lens[i] !== 9) begin
          errors++;
          $display("FAIL rr_grant%0d: got idx %0d len %0d expected idx %0d len 9",
                   i, order[i], lens[i], exp_order[i]);
        end
        $display("test_round_robin: grant %0d to requester %0d for %0d cycles", i, order[i], lens[i]);
      end
    end
  endtask

  task automatic test_zero_code();
    logic [W-1:0] o, e;
    int pulses;
    logic prev_led;
    do_reset();
    req      = 4'b0110;
    code     = 16'h0200;
    pulses   = 0;
    prev_led = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      tick(o, e);
      checks++;
      if (o !== e || o[1] !== 1'b0) begin
        errors++;
        $display("FAIL zero_code t=%0d: got %b expected %b", t, o, e);
      end
      if (t <= 17 && o[W-1] && !prev_led) pulses++;
      prev_led = o[W-1];
    end
    req = '0;
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL zero_code_pulses: got %0d expected 2", pulses);
    end
    $display("test_zero_code: requester 2 played %0d pulses", pulses);
  endtask

  task automatic test_latch();
    logic [W-1:0] o, e;
    int pulses;
    int done_t;
    logic prev_led;
    do_reset();
    req      = 4'b0001;
    code     = 16'h0002;
    pulses   = 0;
    done_t   = -1;
    prev_led = 1'b0;
    for (int t = 1; t <= 22; t++) begin
      tick(o, e);
      if (t == 2) begin
        req  = '0;
        code = 16'h0007;
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL latch_model t=%0d: got %b expected %b", t, o, e);
      end
      if (o[W-1] && !prev_led) pulses++;
      prev_led = o[W-1];
      if (o[N_REQ] === 1'b1 && done_t < 0) done_t = t;
    end
    checks++;
    if (pulses !== 2 || done_t !== 17) begin
      errors++;
      $display("FAIL latch: got pulses %0d done %0d expected pulses 2 done 17", pulses, done_t);
    end
    $display("test_latch: %0d pulses, done at t=%0d", pulses, done_t);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] o, e;
    do_reset();
    req  = 4'b0001;
    code = 16'h0023;
    for (int t = 1; t <= 9; t++) tick(o, e);
    checks++;
    if (o[W-1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_led: got %b expected 1", o[W-1]);
    end
    RST = 1'b1;
    req = 4'b0011;
    tick(o, e);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL mid_abort: got %b expected %b", o, {W{1'b0}});
    end
    RST = 1'b0;
    tick(o, e);
    checks++;
    if (o[N_REQ-1:0] !== 4'b0001 || o !== e) begin
      errors++;
      $display("FAIL mid_regrant: got %b expected %b", o, e);
    end
    for (int t = 0; t < 20; t++) begin
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_model: got %b expected %b", o, e);
      end
    end
    req = '0;
    $display("test_reset_mid: requester 0 regranted after abort");
  endtask

  task automatic test_random();
    logic [W-1:0] o, e;
    do_reset();
    for (int t = 0; t < 900; t++) begin
      if ($urandom_range(5, 0) == 0) begin
        req  = N_REQ'($urandom);
        code = (N_REQ*CODE_W)'($urandom) & (N_REQ*CODE_W)'($urandom | 32'h3333_3333);
      end
      RST = ($urandom_range(249, 0) == 0);
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random t=%0d: got %b expected %b", t, o, e);
      end
    end
    RST = 1'b0;
    req = '0;
    $display("test_random complete");
  endtask

  initial begin
    test_reset();
    test_single_code();
    test_round_robin();
    test_zero_code();
    test_latch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
